pipeline_ctrl: RTL and testbench

- Central stall/flush controller for the 5-stage RISC-V pipeline.
- Drives write enables and flush strobes for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Handles three events:
  - load-use hazards;
  - branches taken, resolved in MEM;
  - multi-cycle data-memory accesses, using a req/ready handshake with a timeout watchdog.
- Also keeps a saturating stall-cycle performance counter.

---
 rtl/pipeline_ctrl_if.sv | 38 +++
 rtl/pipeline_ctrl.sv | 137 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the pipeline datapath and its stall/flush controller.
// The controller uses the slave view; whatever models the datapath uses the master view.
interface pipeline_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             MemRead_EX;
  logic [4:0]       RD_EX;
  logic [4:0]       RS1_ID;
  logic [4:0]       RS2_ID;
  logic             PCSrc_MEM;
  logic             MemRead_MEM;
  logic             MemWrite_MEM;
  logic             dmem_ready;

  logic             PC_write;
  logic             IF_ID_write;
  logic             ID_EX_write;
  logic             EX_MEM_write;
  logic             MEM_WB_write;
  logic             IF_ID_flush;
  logic             ID_EX_flush;
  logic             EX_MEM_flush;
  logic             dmem_req;
  logic             timeout_err;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output MemRead_EX, RD_EX, RS1_ID, RS2_ID, PCSrc_MEM, MemRead_MEM, MemWrite_MEM, dmem_ready,
    input  PC_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write,
    input  IF_ID_flush, ID_EX_flush, EX_MEM_flush, dmem_req, timeout_err, stall_cnt
  );

  modport slave (
    input  MemRead_EX, RD_EX, RS1_ID, RS2_ID, PCSrc_MEM, MemRead_MEM, MemWrite_MEM, dmem_ready,
    output PC_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write,
    output IF_ID_flush, ID_EX_flush, EX_MEM_flush, dmem_req, timeout_err, stall_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use stalls, taken-branch
// squashes, and freezing the whole pipe while a slow data-memory access completes.
// A watchdog parks the block in an error state if memory never answers.
module pipeline_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic          clk,
  input  logic          reset,
  pipeline_ctrl_if.slave bus
);

  localparam int               TMR_W    = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  state_t           r_state;
  logic [TMR_W-1:0] r_timer;
  logic [CNT_W-1:0] r_stallCnt;
  logic             r_timeoutErr;

  logic w_memOp;
  logic w_loadUse;
  logic w_memStall;
  logic w_resolve;
  logic w_pcWrite;
  logic w_ifIdWrite;
  logic w_idExWrite;
  logic w_exMemWrite;
  logic w_memWbWrite;
  logic w_ifIdFlush;
  logic w_idExFlush;
  logic w_exMemFlush;
  logic w_dmemReq;

  assign w_memOp    = bus.MemRead_MEM | bus.MemWrite_MEM;
  assign w_loadUse  = bus.MemRead_EX && (bus.RD_EX != 5'd0) &&
                      ((bus.RD_EX == bus.RS1_ID) || (bus.RD_EX == bus.RS2_ID));
  // A fresh access that memory cannot finish this cycle freezes everything.
  assign w_memStall = (r_state == RUN) && w_memOp && !bus.dmem_ready;
  // Cycles where branch/load-use rules apply: normal RUN, or the exit cycle of a wait.
  assign w_resolve  = ((r_state == RUN) && !w_memStall) ||
                      ((r_state == MEM_WAIT) && bus.dmem_ready);

  // Mealy control decode; everything is held low while reset is asserted.
  always_comb begin
    w_pcWrite    = 1'b0;
    w_ifIdWrite  = 1'b0;
    w_idExWrite  = 1'b0;
    w_exMemWrite = 1'b0;
    w_memWbWrite = 1'b0;
    w_ifIdFlush  = 1'b0;
    w_idExFlush  = 1'b0;
    w_exMemFlush = 1'b0;
    w_dmemReq    = 1'b0;
    if (reset) begin
      case (r_state)
        RUN:      w_dmemReq = w_memOp;
        MEM_WAIT: w_dmemReq = 1'b1;
        default:  w_dmemReq = 1'b0;
      endcase
      if (w_resolve) begin
        w_idExWrite  = 1'b1;
        w_exMemWrite = 1'b1;
        w_memWbWrite = 1'b1;
        if (bus.PCSrc_MEM) begin
          w_pcWrite    = 1'b1;
          w_ifIdWrite  = 1'b1;
          w_ifIdFlush  = 1'b1;
          w_idExFlush  = 1'b1;
          w_exMemFlush = 1'b1;
        end else if (w_loadUse) begin
          w_idExFlush  = 1'b1;
        end else begin
          w_pcWrite    = 1'b1;
          w_ifIdWrite  = 1'b1;
        end
      end
    end
  end

  // State, watchdog timer, sticky error flag and saturating stall counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= RUN;
      r_timer      <= '0;
      r_stallCnt   <= '0;
      r_timeoutErr <= 1'b0;
    end else begin
      if (!w_pcWrite && (r_stallCnt != {CNT_W{1'b1}})) begin
        r_stallCnt <= r_stallCnt + CNT_W'(1);
      end
      case (r_state)
        RUN: begin
          if (w_memStall) begin
            r_state <= MEM_WAIT;
            r_timer <= '0;
          end
        end
        MEM_WAIT: begin
          if (bus.dmem_ready) begin
            r_state <= RUN;
          end else if (r_timer == TMR_LAST) begin
            r_state      <= ERR;
            r_timeoutErr <= 1'b1;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        ERR: begin
          r_timeoutErr <= 1'b1;
        end
        default: begin
          r_state <= RUN;
        end
      endcase
    end
  end

  assign bus.PC_write     = w_pcWrite;
  assign bus.IF_ID_write  = w_ifIdWrite;
  assign bus.ID_EX_write  = w_idExWrite;
  assign bus.EX_MEM_write = w_exMemWrite;
  assign bus.MEM_WB_write = w_memWbWrite;
  assign bus.IF_ID_flush  = w_ifIdFlush;
  assign bus.ID_EX_flush  = w_idExFlush;
  assign bus.EX_MEM_flush = w_exMemFlush;
  assign bus.dmem_req     = w_dmemReq;
  assign bus.timeout_err  = r_timeoutErr;
  assign bus.stall_cnt    = r_stallCnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: fixed vector table, hand-built memory/branch/reset
// sequences, and random traffic compared against a cycle-level behavioural model.
module tb_pipeline_ctrl;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic       memReadEx;
    logic [4:0] rdEx;
    logic [4:0] rs1Id;
    logic [4:0] rs2Id;
    logic       pcSrc;
    logic       memReadMem;
    logic       memWriteMem;
    logic       dmemReady;
  } stim_t;

  // Bit order: PC, IF/ID, ID/EX, EX/MEM, MEM/WB writes; IF/ID, ID/EX, EX/MEM flushes; dmem_req.
  typedef struct packed {
    logic pcW;
    logic ifIdW;
    logic idExW;
    logic exMemW;
    logic memWbW;
    logic ifIdF;
    logic idExF;
    logic exMemF;
    logic req;
  } outs_t;

  typedef struct packed {
    stim_t s;
    outs_t e;
  } vec_t;

  logic clk;
  logic reset;

  pipeline_ctrl_if #(.CNT_W(CNT_W)) bus();
  pipeline_ctrl_if #(.CNT_W(3))     busS();

  pipeline_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Minimum legal timeout and a tiny counter, left stuck in a dead access.
  pipeline_ctrl #(.TIMEOUT(2), .CNT_W(3)) dutSmall (
    .clk   (clk),
    .reset (reset),
    .bus   (busS)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model: waiting on memory, how many unanswered wait cycles, dead, stall count.
  bit mWait;
  bit mErr;
  int mWaited;
  int mCnt;

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic stim_t mk(input logic ld, input int rd, input int rs1, input int rs2,
                               input logic br, input logic mr, input logic mw, input logic rdy);
    stim_t s;
    s.memReadEx   = ld;
    s.rdEx        = 5'(rd);
    s.rs1Id       = 5'(rs1);
    s.rs2Id       = 5'(rs2);
    s.pcSrc       = br;
    s.memReadMem  = mr;
    s.memWriteMem = mw;
    s.dmemReady   = rdy;
    return s;
  endfunction

  function automatic vec_t mkVec(input stim_t s, input logic [8:0] e);
    vec_t v;
    v.s = s;
    v.e = e;
    return v;
  endfunction

  function automatic outs_t sampleOuts();
    return {bus.PC_write, bus.IF_ID_write, bus.ID_EX_write, bus.EX_MEM_write, bus.MEM_WB_write,
            bus.IF_ID_flush, bus.ID_EX_flush, bus.EX_MEM_flush, bus.dmem_req};
  endfunction

  // Expected controls from the pipeline rules given the model's current situation.
  function automatic outs_t modelOuts(input stim_t s);
    outs_t o;
    bit    memOp;
    bit    loadUse;
    bit    frozen;
    o       = '0;
    memOp   = s.memReadMem || s.memWriteMem;
    loadUse = s.memReadEx && (s.rdEx != 0) && ((s.rdEx == s.rs1Id) || (s.rdEx == s.rs2Id));
    if (!reset || mErr) return o;
    o.req  = mWait ? 1'b1 : memOp;
    frozen = !s.dmemReady && (mWait || memOp);
    if (frozen) return o;
    o.idExW  = 1'b1;
    o.exMemW = 1'b1;
    o.memWbW = 1'b1;
    if (s.pcSrc) begin
      o.pcW   = 1'b1;
      o.ifIdW = 1'b1;
      o.ifIdF = 1'b1;
      o.idExF = 1'b1;
      o.exMemF = 1'b1;
    end else if (loadUse) begin
      o.idExF = 1'b1;
    end else begin
      o.pcW   = 1'b1;
      o.ifIdW = 1'b1;
    end
    return o;
  endfunction

  // Advance the model across one rising edge.
  task automatic modelAdvance(input stim_t s, input outs_t o);
    if (!reset) return;
    if (!o.pcW && mCnt < CNT_MAX) mCnt++;
    if (mErr) return;
    if (mWait) begin
      if (s.dmemReady) begin
        mWait = 1'b0;
      end else begin
        mWaited++;
        if (mWaited == TIMEOUT) begin
          mErr  = 1'b1;
          mWait = 1'b0;
        end
      end
    end else if ((s.memReadMem || s.memWriteMem) && !s.dmemReady) begin
      mWait   = 1'b1;
      mWaited = 0;
    end
  endtask

  task automatic modelReset();
    mWait   = 1'b0;
    mErr    = 1'b0;
    mWaited = 0;
    mCnt    = 0;
  endtask

  task automatic driveInputs(input stim_t s);
    bus.MemRead_EX   = s.memReadEx;
    bus.RD_EX        = s.rdEx;
    bus.RS1_ID       = s.rs1Id;
    bus.RS2_ID       = s.rs2Id;
    bus.PCSrc_MEM    = s.pcSrc;
    bus.MemRead_MEM  = s.memReadMem;
    bus.MemWrite_MEM = s.memWriteMem;
    bus.dmem_ready   = s.dmemReady;
  endtask

  task automatic applyStimulus(input stim_t s);
    @(negedge clk);
    driveInputs(s);
    #1;
  endtask

  task automatic checkOutput(input string name, input outs_t exp);
    outs_t act;
    act = sampleOuts();
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: controls got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic checkValue(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkRegs(input string name);
    logic [CNT_W-1:0] expCnt;
    expCnt = CNT_W'(mCnt);
    vectors++;
    if (bus.stall_cnt !== expCnt || bus.timeout_err !== mErr) begin
      miscompares++;
      $display("[TB] FAIL %s regs: stall_cnt=%0d timeout_err=%b, expected %0d / %b",
               name, bus.stall_cnt, bus.timeout_err, expCnt, mErr);
    end
  endtask

  task automatic runStep(input string name, input stim_t s);
    outs_t exp;
    applyStimulus(s);
    exp = modelOuts(s);
    checkOutput(name, exp);
    checkRegs(name);
    modelAdvance(s, exp);
  endtask

  vec_t  tbl[12];
  stim_t cur;
  int    cntRef;

  // Main test sequence.
  initial begin
    tbl[0]  = mkVec(mk(0, 0, 0, 0, 0, 0, 0, 1), 9'b11111_000_0);
    tbl[1]  = mkVec(mk(1, 5, 3, 5, 0, 0, 0, 1), 9'b00111_010_0);
    tbl[2]  = mkVec(mk(1, 7, 7, 2, 0, 0, 0, 0), 9'b00111_010_0);
    tbl[3]  = mkVec(mk(1, 0, 0, 0, 0, 0, 0, 1), 9'b11111_000_0);
    tbl[4]  = mkVec(mk(0, 5, 5, 5, 0, 0, 0, 1), 9'b11111_000_0);
    tbl[5]  = mkVec(mk(1, 4, 3, 6, 0, 0, 0, 1), 9'b11111_000_0);
    tbl[6]  = mkVec(mk(1, 5, 1, 5, 1, 0, 0, 1), 9'b11111_111_0);
    tbl[7]  = mkVec(mk(0, 0, 0, 0, 1, 0, 0, 0), 9'b11111_111_0);
    tbl[8]  = mkVec(mk(0, 0, 0, 0, 0, 1, 0, 1), 9'b11111_000_1);
    tbl[9]  = mkVec(mk(1, 9, 9, 0, 0, 0, 1, 1), 9'b00111_010_1);
    tbl[10] = mkVec(mk(1, 9, 9, 0, 1, 0, 1, 1), 9'b11111_111_1);
    tbl[11] = mkVec(mk(1, 31, 0, 31, 0, 0, 0, 1), 9'b00111_010_0);

    modelReset();
    driveInputs('0);
    busS.MemRead_EX   = 1'b0;
    busS.RD_EX        = 5'd0;
    busS.RS1_ID       = 5'd0;
    busS.RS2_ID       = 5'd0;
    busS.PCSrc_MEM    = 1'b0;
    busS.MemRead_MEM  = 1'b0;
    busS.MemWrite_MEM = 1'b1;
    busS.dmem_ready   = 1'b0;
    reset = 1'b1;
    #2 reset = 1'b0;

    // Under reset every control must stay low even with hazards and a pending access.
    runStep("in_reset_a", mk(1, 5, 5, 5, 0, 1, 0, 0));
    runStep("in_reset_b", mk(1, 5, 5, 5, 1, 0, 1, 0));
    driveInputs('0);
    reset = 1'b1;

    $display("[TB] vector table");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(tbl[i].s);
      checkOutput($sformatf("vec%0d", i), tbl[i].e);
      checkRegs($sformatf("vec%0d", i));
      modelAdvance(tbl[i].s, tbl[i].e);
    end

    $display("[TB] memory wait of three cycles");
    cntRef = mCnt;
    cur = mk(0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) runStep("mw_stall", cur);
    cur.dmemReady = 1'b1;
    runStep("mw_exit", cur);
    checkOutput("mw_exit_const", 9'b11111_000_1);
    runStep("mw_after", mk(0, 0, 0, 0, 0, 0, 0, 1));
    checkValue("mw_cnt_delta", int'(bus.stall_cnt) - cntRef, 3);

    $display("[TB] branch and load-use pending behind an access");
    cur = mk(1, 5, 5, 0, 1, 1, 0, 0);
    runStep("br_wait", cur);
    cur.dmemReady = 1'b1;
    runStep("br_exit", cur);
    checkOutput("br_exit_const", 9'b11111_111_1);
    cur = mk(1, 5, 0, 5, 0, 0, 1, 0);
    runStep("lu_wait", cur);
    runStep("lu_wait2", cur);
    cur.dmemReady = 1'b1;
    runStep("lu_exit", cur);
    checkOutput("lu_exit_const", 9'b00111_010_1);

    $display("[TB] random traffic");
    cur = '0;
    for (int i = 0; i < 400; i++) begin
      if (!mWait) begin
        cur.memReadEx = 1'($urandom_range(0, 1));
        cur.rdEx      = 5'($urandom_range(0, 3));
        cur.rs1Id     = 5'($urandom_range(0, 3));
        cur.rs2Id     = 5'($urandom_range(0, 3));
        cur.pcSrc     = ($urandom_range(0, 4) == 0);
        case ($urandom_range(0, 3))
          0:       begin cur.memReadMem = 1'b1; cur.memWriteMem = 1'b0; end
          1:       begin cur.memReadMem = 1'b0; cur.memWriteMem = 1'b1; end
          default: begin cur.memReadMem = 1'b0; cur.memWriteMem = 1'b0; end
        endcase
      end
      cur.dmemReady = ($urandom_range(0, 2) != 0);
      runStep("rand", cur);
    end

    // The small instance has been stuck on a dead access since reset release.
    checkValue("small_cnt_sat", int'(busS.stall_cnt), 7);
    checkValue("small_err", int'(busS.timeout_err), 1);
    checkValue("small_req", int'(busS.dmem_req), 0);
    checkValue("small_pcw", int'(busS.PC_write), 0);

    $display("[TB] asynchronous reset during a wait");
    cur = mk(0, 0, 0, 0, 0, 0, 1, 1);
    runStep("pre_rst_idle", cur);
    cur.dmemReady = 1'b0;
    runStep("rst_enter", cur);
    runStep("rst_wait", cur);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    modelReset();
    checkOutput("async_rst_outs", '0);
    checkRegs("async_rst");
    driveInputs('0);
    runStep("rst_hold", '0);
    reset = 1'b1;

    $display("[TB] watchdog timeout");
    cur = mk(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < TIMEOUT + 1; i++) runStep("tmo_stall", cur);
    runStep("tmo_err", cur);
    checkValue("tmo_err_flag", int'(bus.timeout_err), 1);
    checkValue("tmo_stall_cnt", int'(bus.stall_cnt), TIMEOUT + 1);
    cur.dmemReady = 1'b1;
    for (int i = 0; i < 3; i++) runStep("err_hold", cur);
    checkOutput("err_hold_const", '0);

    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    modelReset();
    checkOutput("final_rst_outs", '0);
    checkRegs("final_rst");
    checkValue("final_rst_cnt", int'(bus.stall_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
